// File: rtl/irq_claim_decoder.sv
// Interrupt pending/claim/complete controller for 16 request lines.
// Lines latch into pending, a masked line is claimed into service, and service ends on a matching completion.
module irq_claim_decoder #(
  parameter int unsigned EDGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] src,
  input  logic        mask_we,
  input  logic [15:0] mask_wdata,
  input  logic        claim_valid,
  input  logic [3:0]  claim_num,
  input  logic        done_valid,
  input  logic [3:0]  done_num,
  output logic [15:0] pending,
  output logic [15:0] req_vec,
  output logic [15:0] in_service,
  output logic        busy,
  output logic        err
);

  localparam int unsigned N = 16;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_SERVICE = 1'b1;

  logic         r_state;
  logic [N-1:0] r_pending;
  logic [N-1:0] r_mask;
  logic [N-1:0] r_in_service;
  logic         r_err;

  logic         w_state_next;
  logic [N-1:0] w_set_vec;
  logic [N-1:0] w_clr_vec;
  logic [N-1:0] w_pending_next;
  logic [N-1:0] w_in_service_next;
  logic [N-1:0] w_claim_oh;
  logic         w_claim_ok;
  logic         w_done_ok;
  logic         w_err_next;

  // Edge mode: src is registered, then the edge is taken between the two register stages.
  if (EDGE != 0) begin : g_edge
    logic [N-1:0] r_src_s;
    logic [N-1:0] r_src_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_src_s <= '0;
        r_src_q <= '0;
      end else begin
        r_src_s <= src;
        r_src_q <= r_src_s;
      end
    end

    assign w_set_vec = r_src_s & ~r_src_q;
  end else begin : g_level
    assign w_set_vec = src;
  end

  assign w_claim_oh = N'(1) << claim_num;
  assign req_vec    = r_pending & r_mask;
  assign pending    = r_pending;
  assign in_service = r_in_service;
  assign busy       = (r_state == ST_SERVICE);
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_mask       <= '1;
      r_in_service <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pending    <= w_pending_next;
      r_in_service <= w_in_service_next;
      r_err        <= w_err_next;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
    end
  end

  // A claim is only considered in IDLE and a completion only in SERVICE, so both never take effect together.
  always_comb begin
    w_state_next      = r_state;
    w_clr_vec         = '0;
    w_in_service_next = r_in_service;
    w_claim_ok        = 1'b0;
    w_done_ok         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_claim_ok = claim_valid && req_vec[claim_num];
        if (w_claim_ok) begin
          w_clr_vec         = w_claim_oh;
          w_in_service_next = w_claim_oh;
          w_state_next      = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        w_done_ok = done_valid && r_in_service[done_num];
        if (w_done_ok) begin
          w_in_service_next = '0;
          w_state_next      = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    w_err_next     = (claim_valid && !w_claim_ok) || (done_valid && !w_done_ok);
    w_pending_next = (r_pending & ~w_clr_vec) | w_set_vec;
  end

endmodule

// File: tb/tb_irq_claim_decoder.sv
// Directed bench for irq_claim_decoder (EDGE=1): claim, complete, mask, reject and reset scenarios.
module tb_irq_claim_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        claim_valid;
  logic [3:0]  claim_num;
  logic        done_valid;
  logic [3:0]  done_num;
  logic [15:0] pending;
  logic [15:0] req_vec;
  logic [15:0] in_service;
  logic        busy;
  logic        err;

  int vectors    = 0;
  int miscompares = 0;

  irq_claim_decoder #(.EDGE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .claim_valid(claim_valid),
    .claim_num  (claim_num),
    .done_valid (done_valid),
    .done_num   (done_num),
    .pending    (pending),
    .req_vec    (req_vec),
    .in_service (in_service),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; src = '0; mask_we = 1'b0; mask_wdata = '0;
    claim_valid = 1'b0; claim_num = '0; done_valid = 1'b0; done_num = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pending", pending, 16'h0000);
    chk("rst_in_service", in_service, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_err", 16'(err), 16'h0000);

    // src[5] rises and is held: pending appears on the second edge
    src = 16'h0020;
    tick();
    chk("edge5_c1_pending", pending, 16'h0000);
    tick();
    chk("edge5_c2_pending", pending, 16'h0020);
    chk("edge5_c2_req", req_vec, 16'h0020);
    tick();
    chk("edge5_held_pending", pending, 16'h0020);

    // claim line 5
    claim_valid = 1'b1; claim_num = 4'd5;
    tick();
    claim_valid = 1'b0;
    chk("claim5_pending", pending, 16'h0000);
    chk("claim5_in_service", in_service, 16'h0020);
    chk("claim5_busy", 16'(busy), 16'h0001);
    chk("claim5_err", 16'(err), 16'h0000);
    tick();
    chk("held_no_reset_pending", pending, 16'h0000);

    // wrong completion, then correct one
    done_valid = 1'b1; done_num = 4'd3;
    tick();
    done_valid = 1'b0;
    chk("done3_err", 16'(err), 16'h0001);
    chk("done3_in_service", in_service, 16'h0020);
    chk("done3_busy", 16'(busy), 16'h0001);
    tick();
    chk("done3_err_pulse_end", 16'(err), 16'h0000);
    done_valid = 1'b1; done_num = 4'd5;
    tick();
    done_valid = 1'b0;
    chk("done5_in_service", in_service, 16'h0000);
    chk("done5_busy", 16'(busy), 16'h0000);
    chk("done5_err", 16'(err), 16'h0000);

    // masked line 0 cannot be claimed
    src = 16'h0000;
    mask_we = 1'b1; mask_wdata = 16'hFFFE;
    tick();
    mask_we = 1'b0;
    src = 16'h0001;
    tick(); tick();
    chk("mask_pending", pending, 16'h0001);
    chk("mask_req", req_vec, 16'h0000);
    claim_valid = 1'b1; claim_num = 4'd0;
    tick();
    claim_valid = 1'b0;
    chk("masked_claim_err", 16'(err), 16'h0001);
    chk("masked_claim_pending", pending, 16'h0001);
    chk("masked_claim_busy", 16'(busy), 16'h0000);
    chk("masked_claim_in_service", in_service, 16'h0000);
    mask_we = 1'b1; mask_wdata = 16'hFFFF;
    tick();
    mask_we = 1'b0;
    chk("unmask_req", req_vec, 16'h0001);

    // claim line 2 in the same cycle a fresh src[2] edge sets it
    src = 16'h0005;
    tick(); tick();
    chk("line2_pending", pending, 16'h0005);
    src = 16'h0001;
    tick(); tick();
    src = 16'h0005;
    tick();
    claim_valid = 1'b1; claim_num = 4'd2;
    tick();
    claim_valid = 1'b0;
    chk("setwins_pending", pending, 16'h0005);
    chk("setwins_in_service", in_service, 16'h0004);
    chk("setwins_busy", 16'(busy), 16'h0001);

    // claim and completion together in SERVICE: completion wins, claim rejected
    claim_valid = 1'b1; claim_num = 4'd0;
    done_valid = 1'b1; done_num = 4'd2;
    tick();
    claim_valid = 1'b0; done_valid = 1'b0;
    chk("both_err", 16'(err), 16'h0001);
    chk("both_busy", 16'(busy), 16'h0000);
    chk("both_in_service", in_service, 16'h0000);
    chk("both_pending", pending, 16'h0005);

    // completion in IDLE is rejected
    done_valid = 1'b1; done_num = 4'd2;
    tick();
    done_valid = 1'b0;
    chk("idle_done_err", 16'(err), 16'h0001);
    chk("idle_done_busy", 16'(busy), 16'h0000);

    // reach SERVICE with pending 8001, zero the mask, then reset
    claim_valid = 1'b1; claim_num = 4'd2;
    tick();
    claim_valid = 1'b0;
    chk("claim2_pending", pending, 16'h0001);
    src = 16'h8001;
    mask_we = 1'b1; mask_wdata = 16'h0000;
    tick();
    mask_we = 1'b0;
    tick();
    chk("pre_rst_pending", pending, 16'h8001);
    chk("pre_rst_req", req_vec, 16'h0000);
    chk("pre_rst_busy", 16'(busy), 16'h0001);
    rst = 1'b1; claim_valid = 1'b1; claim_num = 4'd0;
    tick();
    rst = 1'b0; claim_valid = 1'b0;
    chk("rst2_pending", pending, 16'h0000);
    chk("rst2_in_service", in_service, 16'h0000);
    chk("rst2_busy", 16'(busy), 16'h0000);
    chk("rst2_err", 16'(err), 16'h0000);
    // src still high after reset: edge detector restarts and mask is back to all-ones
    tick(); tick();
    chk("rst2_repend", pending, 16'h8001);
    chk("rst2_mask_ffff", req_vec, 16'h8001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
